// File: rtl/prog_sequencer.sv
// -----------------------------------------------------------------------------
// prog_sequencer
//   Run controller in front of the program counter. A rising edge on the
//   bench request (seen while IDLE) walks the PC through
//   clear -> start pulse -> launch -> entry jump -> run -> done.
//   While running, core branch requests are forwarded to the PC with a
//   one-cycle register stage. Busy/done status and a per-program RUN-cycle
//   count are reported back to the bench. Every output is a flop (Moore).
//
//   Optional feature macro: PROG_SEQ_WATCHDOG_EN
//     defined   : RUN ends with timeout=1 once cycle_cnt reaches TIMEOUT
//     undefined : timeout stays 0; RUN lasts until halt
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-low reset
//   req_start     in   bench request (level); rising edge in IDLE launches
//   entry_addr    in   [A]  program entry, sampled on the accepted request
//   halt          in   core executed halt; honoured only in RUN
//   core_br_en    in   core branch request
//   core_target   in   [A]  core branch target
//   pc_reset      out  synchronous clear to the PC (active-high)
//   pc_start      out  start to the PC
//   pc_branch_en  out  branch enable to the PC
//   pc_target     out  [A]  branch target to the PC
//   busy          out  high in CLEAR..RUN
//   done          out  high in DONE
//   timeout       out  high when the watchdog ended the last run
//   cycle_cnt     out  [CW] RUN cycles of the last or current program
// -----------------------------------------------------------------------------
module prog_sequencer #(
  parameter int A         = 10,
  parameter int CW        = 16,
  parameter int START_CYC = 2,
  parameter int TIMEOUT   = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_start,
  input  logic [A-1:0]  entry_addr,
  input  logic          halt,
  input  logic          core_br_en,
  input  logic [A-1:0]  core_target,
  output logic          pc_reset,
  output logic          pc_start,
  output logic          pc_branch_en,
  output logic [A-1:0]  pc_target,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycle_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_LAUNCH = 3'd3;
  localparam logic [2:0] S_JUMP   = 3'd4;
  localparam logic [2:0] S_RUN    = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam int             SW         = (START_CYC > 1) ? $clog2(START_CYC) : 1;
  localparam logic [SW-1:0]  START_LAST = SW'(START_CYC - 1);
  localparam logic [CW-1:0]  CNT_MAX    = '1;

  logic [2:0]    r_state, w_nxt_state;
  logic [SW-1:0] r_start_cnt, w_start_cnt_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_sat;
  logic          r_tmo, w_tmo_nxt;
  logic          r_req_q;
  logic          r_armed;
  logic [A-1:0]  r_entry;
  logic          w_accept, w_at_limit, w_limit;

  logic          r_pc_reset, r_pc_start, r_pc_branch_en, r_busy, r_done;
  logic [A-1:0]  r_pc_target;

  // A request already high when reset releases must drop once before it
  // can launch, so edges are only honoured after a low sample has been seen.
  assign w_accept  = (r_state == S_IDLE) && req_start && !r_req_q && r_armed;

  // Saturating increment: the count sticks at all-ones instead of wrapping.
  assign w_cnt_sat = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);

  // Limit is judged on the value the count is about to take, so the run
  // leaves RUN with cycle_cnt == TIMEOUT.
  assign w_at_limit = (32'(w_cnt_sat) == 32'(TIMEOUT));

`ifdef PROG_SEQ_WATCHDOG_EN
  assign w_limit = w_at_limit;
`else
  // Watchdog compiled out; the compare is masked so timeout can never set.
  assign w_limit = w_at_limit & 1'b0;
`endif

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_nxt_state     = r_state;
    w_start_cnt_nxt = r_start_cnt;
    w_cnt_nxt       = r_cnt;
    w_tmo_nxt       = r_tmo;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_nxt_state = S_CLEAR;
          w_cnt_nxt   = '0;
          w_tmo_nxt   = 1'b0;
        end
      end
      S_CLEAR: begin
        w_nxt_state     = S_START;
        w_start_cnt_nxt = '0;
      end
      S_START: begin
        if (r_start_cnt == START_LAST) w_nxt_state = S_LAUNCH;
        else                           w_start_cnt_nxt = r_start_cnt + SW'(1);
      end
      S_LAUNCH: w_nxt_state = S_JUMP;
      S_JUMP:   w_nxt_state = S_RUN;
      S_RUN: begin
        w_cnt_nxt = w_cnt_sat;
        // halt has priority over the watchdog in the same cycle.
        if (halt) begin
          w_nxt_state = S_DONE;
        end else if (w_limit) begin
          w_nxt_state = S_DONE;
          w_tmo_nxt   = 1'b1;
        end
      end
      S_DONE: begin
        if (!req_start) w_nxt_state = S_IDLE;
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_start_cnt    <= '0;
      r_cnt          <= '0;
      r_tmo          <= 1'b0;
      r_req_q        <= 1'b0;
      r_armed        <= 1'b0;
      r_entry        <= '0;
      r_pc_reset     <= 1'b0;
      r_pc_start     <= 1'b0;
      r_pc_branch_en <= 1'b0;
      r_pc_target    <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_start_cnt <= w_start_cnt_nxt;
      r_cnt       <= w_cnt_nxt;
      r_tmo       <= w_tmo_nxt;
      r_req_q     <= req_start;
      r_armed     <= r_armed | ~req_start;
      if (w_accept) r_entry <= entry_addr;

      // Outputs are registered from the next state so they line up with it.
      r_pc_reset <= (w_nxt_state == S_CLEAR);
      r_pc_start <= (w_nxt_state == S_START);
      r_busy     <= (w_nxt_state != S_IDLE) && (w_nxt_state != S_DONE);
      r_done     <= (w_nxt_state == S_DONE);

      // RUN forwards the core request one cycle later (including the halt
      // cycle); the entry jump is issued while in JUMP; otherwise quiet.
      if (r_state == S_RUN) begin
        r_pc_branch_en <= core_br_en;
        r_pc_target    <= core_target;
      end else if (w_nxt_state == S_JUMP) begin
        r_pc_branch_en <= 1'b1;
        r_pc_target    <= r_entry;
      end else begin
        r_pc_branch_en <= 1'b0;
        r_pc_target    <= '0;
      end
    end
  end

  assign pc_reset     = r_pc_reset;
  assign pc_start     = r_pc_start;
  assign pc_branch_en = r_pc_branch_en;
  assign pc_target    = r_pc_target;
  assign busy         = r_busy;
  assign done         = r_done;
  assign timeout      = r_tmo;
  assign cycle_cnt    = r_cnt;

endmodule

// File: tb/tb_prog_sequencer.sv
// -----------------------------------------------------------------------------
// tb_prog_sequencer
//   Two instances share one randomized stimulus stream: one with a 16-bit
//   counter and TIMEOUT=16, one with a 4-bit counter (saturation). Each is
//   compared every cycle against a timeline model: a run is tracked as the
//   number of cycles since the accepted request, and expected outputs are
//   derived from that position.
// -----------------------------------------------------------------------------
module tb_prog_sequencer;

  localparam int A     = 10;
  localparam int SC    = 2;
  localparam int CW0   = 16;
  localparam int TO0   = 16;
  localparam int CW1   = 4;
  localparam int TO1   = 4096;
  localparam int RUN_T = 4 + SC;  // position of the first RUN cycle
`ifdef PROG_SEQ_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          req_start;
  logic [A-1:0]  entry_addr;
  logic          halt;
  logic          core_br_en;
  logic [A-1:0]  core_target;

  logic [1:0]    o_pc_reset, o_pc_start, o_pc_branch_en, o_busy, o_done, o_timeout;
  logic [A-1:0]  o_pc_target [2];
  logic [CW0-1:0] o_cnt_a;
  logic [CW1-1:0] o_cnt_b;

  int n_vec = 0;
  int n_err = 0;

  // Model state per instance: mode 0=idle 1=busy 2=done, t=cycles since accept.
  int           m_mode [2];
  int           m_t    [2];
  int           m_cnt  [2];
  logic         m_tmo  [2];
  logic [A-1:0] m_entry[2];
  logic         m_br   [2];
  logic [A-1:0] m_tg   [2];
  logic         m_prev;
  logic         m_armed;

  prog_sequencer #(.A(A), .CW(CW0), .START_CYC(SC), .TIMEOUT(TO0)) dut_a (
    .clk(clk), .reset(reset), .req_start(req_start), .entry_addr(entry_addr),
    .halt(halt), .core_br_en(core_br_en), .core_target(core_target),
    .pc_reset(o_pc_reset[0]), .pc_start(o_pc_start[0]),
    .pc_branch_en(o_pc_branch_en[0]), .pc_target(o_pc_target[0]),
    .busy(o_busy[0]), .done(o_done[0]), .timeout(o_timeout[0]),
    .cycle_cnt(o_cnt_a)
  );

  prog_sequencer #(.A(A), .CW(CW1), .START_CYC(SC), .TIMEOUT(TO1)) dut_b (
    .clk(clk), .reset(reset), .req_start(req_start), .entry_addr(entry_addr),
    .halt(halt), .core_br_en(core_br_en), .core_target(core_target),
    .pc_reset(o_pc_reset[1]), .pc_start(o_pc_start[1]),
    .pc_branch_en(o_pc_branch_en[1]), .pc_target(o_pc_target[1]),
    .busy(o_busy[1]), .done(o_done[1]), .timeout(o_timeout[1]),
    .cycle_cnt(o_cnt_b)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_t[i] = 0; m_cnt[i] = 0; m_tmo[i] = 1'b0;
      m_entry[i] = '0; m_br[i] = 1'b0; m_tg[i] = '0;
    end
    m_prev  = 1'b0;
    m_armed = 1'b0;
  endtask

  task automatic model_step();
    bit was_run;
    int cmax, to;
    for (int i = 0; i < 2; i++) begin
      cmax    = (i == 0) ? (1 << CW0) - 1 : (1 << CW1) - 1;
      to      = (i == 0) ? TO0 : TO1;
      was_run = (m_mode[i] == 1) && (m_t[i] >= RUN_T);
      m_br[i] = was_run ? core_br_en : 1'b0;
      m_tg[i] = was_run ? core_target : '0;
      case (m_mode[i])
        0: if (req_start && !m_prev && m_armed) begin
             m_mode[i] = 1; m_t[i] = 1; m_entry[i] = entry_addr;
             m_cnt[i] = 0; m_tmo[i] = 1'b0;
           end
        1: if (was_run) begin
             if (m_cnt[i] < cmax) m_cnt[i]++;
             if (halt) m_mode[i] = 2;
             else if (WD && m_cnt[i] == to) begin m_mode[i] = 2; m_tmo[i] = 1'b1; end
           end else begin
             m_t[i]++;
           end
        default: if (!req_start) m_mode[i] = 0;
      endcase
      if (m_mode[i] == 1 && m_t[i] == RUN_T - 1) begin
        m_br[i] = 1'b1;
        m_tg[i] = m_entry[i];
      end
    end
    m_armed = m_armed | ~req_start;
    m_prev  = req_start;
  endtask

  task automatic check_all(input string tag);
    bit bsy;
    for (int i = 0; i < 2; i++) begin
      bsy = (m_mode[i] == 1);
      check($sformatf("%s/%0d/pc_reset", tag, i), 32'(o_pc_reset[i]), 32'(bsy && m_t[i] == 1));
      check($sformatf("%s/%0d/pc_start", tag, i), 32'(o_pc_start[i]),
            32'(bsy && m_t[i] >= 2 && m_t[i] <= 1 + SC));
      check($sformatf("%s/%0d/br_en", tag, i), 32'(o_pc_branch_en[i]), 32'(m_br[i]));
      check($sformatf("%s/%0d/target", tag, i), 32'(o_pc_target[i]), 32'(m_tg[i]));
      check($sformatf("%s/%0d/busy", tag, i), 32'(o_busy[i]), 32'(bsy));
      check($sformatf("%s/%0d/done", tag, i), 32'(o_done[i]), 32'(m_mode[i] == 2));
      check($sformatf("%s/%0d/timeout", tag, i), 32'(o_timeout[i]), 32'(m_tmo[i]));
      check($sformatf("%s/%0d/cycle_cnt", tag, i),
            (i == 0) ? 32'(o_cnt_a) : 32'(o_cnt_b), 32'(m_cnt[i]));
    end
  endtask

  int halt_div;

  initial begin
    reset = 1'b0; req_start = 1'b1; entry_addr = '0; halt = 1'b0;
    core_br_en = 1'b0; core_target = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");

    // Request held high across reset release must not launch.
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); model_step(); #1 check_all("held_req");
      @(negedge clk);
    end

    halt_div = 40;
    for (int c = 0; c < 20000; c++) begin
      if (c % 500 == 0) begin
        case ($urandom_range(0, 3))
          0: halt_div = 3;
          1: halt_div = 40;
          2: halt_div = 150;
          default: halt_div = 100000;
        endcase
      end
      @(negedge clk);
      if ($urandom_range(0, 399) == 0 && (m_mode[0] == 1 || m_mode[1] == 1)) begin
        reset = 1'b0;
        #1 model_reset();
        check_all("async_rst");
        @(posedge clk); #1 check_all("in_rst");
        @(negedge clk);
        reset = 1'b1;
      end
      if ($urandom_range(0, 19) == 0) req_start = ~req_start;
      halt        = ($urandom_range(0, halt_div - 1) == 0);
      core_br_en  = ($urandom_range(0, 3) == 0);
      core_target = A'($urandom);
      entry_addr  = A'($urandom);
      @(posedge clk); model_step(); #1 check_all("run");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
